// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised line, false-start rejection,
// per-word parity/framing flags, break detection and valid/ready output.
module uart_rx_param #(
   parameter int CLK_HZ    = 100000000,
   parameter int BAUD      = 1000000,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_nrst,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 break_det
);

   localparam int DIV  = CLK_HZ / BAUD;
   localparam int HALF = DIV / 2;
   localparam int CW   = $clog2(DIV);

   localparam logic [CW-1:0] T_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] T_HALF = CW'(HALF - 1);
   localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);
   localparam logic          S_LAST = 1'(STOP_BITS - 1);

   generate
      if (DIV < 8) begin : g_bad_div
         $error("uart_rx_param: CLK_HZ/BAUD must be >= 8");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_BRK
   } state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync_q;
   logic                 rxs;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 pb_q, pb_d;
   logic                 fe_q, fe_d;
   logic                 st_q, st_d;
   logic                 tick;
   logic                 done;
   logic                 brk;
   logic                 par_x;
   logic                 perr;

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], uart_rx};
      end
   end

   assign rxs = sync_q[1];

   // the start bit is sampled at its middle, every later bit a full DIV on
   assign tick = (state_q == S_START) ? (cnt_q == T_HALF)
                                      : (cnt_q == T_FULL);

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         pb_q    <= 1'b0;
         fe_q    <= 1'b0;
         st_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         pb_q    <= pb_d;
         fe_q    <= fe_d;
         st_q    <= st_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pb_d    = pb_q;
      fe_d    = fe_q;
      st_d    = st_q;
      done    = 1'b0;
      brk     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            fe_d  = 1'b0;
            st_d  = 1'b0;
            if (!rxs) state_d = S_START;
         end
         S_START: begin
            if (tick) begin
               cnt_d = '0;
               if (rxs) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  bit_d   = '0;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               cnt_d = '0;
               sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
               if (bit_q == B_LAST) begin
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_PAR: begin
            if (tick) begin
               cnt_d   = '0;
               pb_d    = rxs;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               cnt_d = '0;
               fe_d  = fe_q | ~rxs;
               // all-zero frame through the first stop bit is a break
               if (!st_q && !rxs && (sh_q == '0) &&
                   ((PARITY == 0) || !pb_q)) begin
                  brk     = 1'b1;
                  state_d = S_BRK;
               end else if (st_q == S_LAST) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  st_d = 1'b1;
               end
            end
         end
         S_BRK: begin
            cnt_d = '0;
            if (rxs) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      par_x = ^{sh_q, pb_q};
      perr  = 1'b0;
      if (PARITY == 1) begin
         perr = ~par_x;
      end else if (PARITY == 2) begin
         perr = par_x;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_nrst) begin
      if (!sys_nrst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         break_det <= brk;
         if (done) begin
            if (rx_valid && !rx_ready) begin
               overrun <= 1'b1;
            end else begin
               rx_data    <= sh_q;
               parity_err <= perr;
               frame_err  <= fe_d;
               rx_valid   <= 1'b1;
               if (rx_valid) overrun <= 1'b0;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
      end
   end

endmodule
